// File: rtl/vec_collect_6_pkg.sv
// Shared types and constants for the 6-lane row-sum collector.
package vec_collect_6_pkg;
  localparam int LANES            = 6;
  localparam int WORD_W           = 32;
  localparam int VEC_W            = LANES * WORD_W;
  localparam int IDX_W            = 3;
  localparam int ADD_LATENCY      = 12;
  localparam int TREE_LATENCY_DEF = 3 * ADD_LATENCY;
  localparam int MAX_DEPTH        = 4;
  localparam int PTR_W            = 2;
  localparam int CRED_W           = 3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction
endpackage

// File: rtl/vec_collect_6_if.sv
// Result vector stream (valid/ready) between the collector and its consumer.
interface vec_collect_6_if;
  import vec_collect_6_pkg::*;

  logic [VEC_W-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;

  modport master (output m_tdata, output m_tvalid, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, output m_tready);
endinterface

// File: rtl/vec_collect_6_tag_dly.sv
// Row tag delay line matching the adder tree latency; cleared by reset so
// in-flight rows are forgotten.
module tag_dly
  import vec_collect_6_pkg::*;
#(
  parameter int STAGES = TREE_LATENCY_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [STAGES-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = tag_in;
    for (int i = 1; i < STAGES; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_out = pipe_q[STAGES-1];

endmodule

// File: rtl/vec_collect_6.sv
// Collects six adder-tree row sums into a result vector and buffers finished
// vectors; credits stop upstream from starting a vector with no buffer slot.
module vec_collect_6
  import vec_collect_6_pkg::*;
#(
  parameter int TREE_LATENCY = TREE_LATENCY_DEF,
  parameter int DEPTH        = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              row_issue,
  output logic              issue_ready,
  input  logic [WORD_W-1:0] S32,
  vec_collect_6_if.master   m,
  output logic              err
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CRED_W-1:0] DEPTH_C = CRED_W'(DEPTH);

  logic [IDX_W-1:0]        row_cnt_q, row_cnt_d;
  logic [CRED_W-1:0]       credits_q, credits_d;
  logic                    err_q, err_d;
  logic [VEC_W-WORD_W-1:0] asm_q, asm_d;
  logic [VEC_W-1:0]        mem_q [MAX_DEPTH];
  logic [VEC_W-1:0]        mem_d [MAX_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CRED_W-1:0]       count_q, count_d;
  logic                    accept, reserve, push, pop;
  tag_t                    tag_in, tag_tail;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Mid-vector rows already own a credit, so only row 0 needs a free one.
  assign issue_ready = (row_cnt_q != '0) || (credits_q != '0);
  assign accept      = row_issue && issue_ready;
  assign reserve     = accept && (row_cnt_q == '0);
  assign m.m_tvalid  = (count_q != '0);
  assign m.m_tdata   = mem_q[rd_ptr_q];
  assign pop         = m.m_tvalid && m.m_tready;
  assign err         = err_q;
  assign tag_in      = '{valid: accept, idx: row_cnt_q};
  assign push        = tag_tail.valid && (tag_tail.idx == LAST_IDX);

  tag_dly #(.STAGES(TREE_LATENCY)) u_tag_dly (
    .clk     (clk),
    .resetn  (resetn),
    .tag_in  (tag_in),
    .tag_out (tag_tail)
  );

  always_comb begin
    row_cnt_d = accept ? next_idx(row_cnt_q) : row_cnt_q;
    err_d     = err_q || (row_issue && !issue_ready);

    credits_d = credits_q;
    if (reserve && !pop) begin
      credits_d = credits_q - CRED_W'(1);
    end else if (pop && !reserve) begin
      credits_d = credits_q + CRED_W'(1);
    end

    asm_d = asm_q;
    for (int k = 0; k < LANES - 1; k++) begin
      if (tag_tail.valid && (tag_tail.idx == IDX_W'(k))) begin
        asm_d[k*WORD_W +: WORD_W] = S32;
      end
    end

    // The last lane goes straight into the FIFO alongside the held lanes.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {S32, asm_q};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CRED_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CRED_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      row_cnt_q <= '0;
      credits_q <= DEPTH_C;
      err_q     <= 1'b0;
      asm_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      row_cnt_q <= row_cnt_d;
      credits_q <= credits_d;
      err_q     <= err_d;
      asm_q     <= asm_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      for (int i = 0; i < MAX_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule
